pc_fetch: RTL and testbench

Instruction-fetch stage of the Hack CPU, sitting directly downstream of the 16-bit incrementer. It owns the program counter, computes PC+1 through an inc16 instance, and fetches instructions from instruction ROM over a req/ack handshake. It delivers each instruction with its address to the CPU over a valid/ready handshake, and it accepts jump redirects from the execute stage.

---
 rtl/pc_fetch_pkg.sv | 13 +
 rtl/pc_fetch_inc16.sv | 10 +
 rtl/pc_fetch.sv | 113 +++++++++++
 tb/tb_pc_fetch.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_pkg.sv
// Shared types for the Hack instruction-fetch stage.
// Holds FSM state encodings and the default reset vector.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2
  } state_t;

  localparam logic [15:0] RESET_VECTOR_DEF = 16'h0000;

endpackage

// File: rtl/pc_fetch_inc16.sv
// 16-bit incrementer used for pc+1 (wraps modulo 2^16).
// Ports: in (16b), out = in + 1 (16b).
module inc16 (
  input  logic [15:0] in,
  output logic [15:0] out
);

  assign out = in + 16'd1;

endmodule

// File: rtl/pc_fetch.sv
// Hack fetch stage: owns pc, fetches over ROM req/ack, delivers
// instr/instr_pc to the CPU over valid/ready, takes jump redirects.
// Ports: clk, reset (async high), jump/jump_addr, imem_req/addr/ack/data,
// instr_valid/ready, instr, instr_pc, pc, fetch_timeout (sticky).
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [7:0]  WAIT_LIMIT   = 8'd15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        jump,
  input  logic [15:0] jump_addr,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic [15:0] pc,
  output logic        fetch_timeout
);

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] ipc_q, ipc_d;
  logic        valid_q, valid_d;
  logic        tout_q, tout_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic [15:0] pc_inc;

  inc16 u_inc (
    .in  (pc_q),
    .out (pc_inc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    tout_d  = tout_q;
    wcnt_d  = wcnt_q;
    if (jump) begin
      // Redirect wins; any coincident ROM data is dropped.
      pc_d    = jump_addr;
      valid_d = 1'b0;
      state_d = REQ;
      wcnt_d  = 8'd0;
    end else begin
      case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (imem_ack) begin
            instr_d = imem_data;
            ipc_d   = pc_q;
            pc_d    = pc_inc;
            valid_d = 1'b1;
            state_d = VALID;
            wcnt_d  = 8'd0;
          end else if (wcnt_q + 8'd1 == WAIT_LIMIT) begin
            // Flag the slow ROM but keep retrying the same address.
            tout_d = 1'b1;
            wcnt_d = 8'd0;
          end else begin
            wcnt_d = wcnt_q + 8'd1;
          end
        end
        VALID: begin
          if (instr_ready) begin
            valid_d = 1'b0;
            state_d = REQ;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_VECTOR;
      instr_q <= 16'h0000;
      ipc_q   <= 16'h0000;
      valid_q <= 1'b0;
      tout_q  <= 1'b0;
      wcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      tout_q  <= tout_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign imem_req      = (state_q == REQ);
  assign imem_addr     = pc_q;
  assign instr_valid   = valid_q;
  assign instr         = instr_q;
  assign instr_pc      = ipc_q;
  assign pc            = pc_q;
  assign fetch_timeout = tout_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: behavioural model + per-cycle compare,
// plus directed scenarios with literal expectations.
module tb_pc_fetch;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        jump = 1'b0;
  logic [15:0] jump_addr = 16'h0000;
  logic        ack_en = 1'b0;
  logic        instr_ready = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic [15:0] pc;
  logic        fetch_timeout;

  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] rom_val(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h1234;
      16'h0001: return 16'h5678;
      16'h0002: return 16'h9ABC;
      16'h0100: return 16'hC0DE;
      16'hFFFF: return 16'hBEEF;
      default:  return a ^ 16'h5A5A;
    endcase
  endfunction

  assign imem_ack  = imem_req & ack_en;
  assign imem_data = rom_val(imem_addr);

  pc_fetch #(
    .RESET_VECTOR (16'h0000),
    .WAIT_LIMIT   (8'(LIM))
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .jump          (jump),
    .jump_addr     (jump_addr),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_data     (imem_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .pc            (pc),
    .fetch_timeout (fetch_timeout)
  );

  always #5 clk = ~clk;

  // Model: "idle" after reset, "fetching" while asking ROM,
  // "holding" while an instruction waits for the CPU.
  bit          m_idle;
  bit          m_fetching;
  bit          m_holding;
  logic [15:0] m_pc;
  logic [15:0] m_instr;
  logic [15:0] m_ipc;
  bit          m_tout;
  int          m_waits;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_idle = 1; m_fetching = 0; m_holding = 0;
      m_pc = 16'h0000; m_instr = 16'h0000; m_ipc = 16'h0000;
      m_tout = 0; m_waits = 0;
    end else if (jump) begin
      m_pc = jump_addr;
      m_idle = 0; m_holding = 0; m_fetching = 1;
      m_waits = 0;
    end else if (m_idle) begin
      m_idle = 0; m_fetching = 1;
    end else if (m_fetching) begin
      if (ack_en) begin
        m_instr = rom_val(m_pc);
        m_ipc = m_pc;
        m_pc = 16'((int'(m_pc) + 1) % 65536);
        m_fetching = 0; m_holding = 1; m_waits = 0;
      end else begin
        m_waits++;
        if (m_waits == LIM) begin
          m_tout = 1;
          m_waits = 0;
        end
      end
    end else if (m_holding && instr_ready) begin
      m_holding = 0; m_fetching = 1;
    end
  end

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
               $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("m.imem_req", 16'(imem_req), 16'(m_fetching));
      if (m_fetching) chk("m.imem_addr", imem_addr, m_pc);
      chk("m.instr_valid", 16'(instr_valid), 16'(m_holding));
      chk("m.instr", instr, m_instr);
      chk("m.instr_pc", instr_pc, m_ipc);
      chk("m.pc", pc, m_pc);
      chk("m.fetch_timeout", 16'(fetch_timeout), 16'(m_tout));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_i [3];
    exp_i[0] = 16'h1234;
    exp_i[1] = 16'h5678;
    exp_i[2] = 16'h9ABC;

    // Test 1: streaming with 1-cycle ROM, ready high
    ack_en = 1'b1;
    instr_ready = 1'b1;
    tick();
    chk("t1.rst_pc", pc, 16'h0000);
    chk("t1.rst_valid", 16'(instr_valid), 16'h0000);
    do_reset();
    tick();
    chk("t1.req0", 16'(imem_req), 16'h0001);
    chk("t1.addr0", imem_addr, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t1.valid", 16'(instr_valid), 16'h0001);
      chk("t1.instr", instr, exp_i[k]);
      chk("t1.ipc", instr_pc, 16'(k));
      tick();
      chk("t1.gap_valid", 16'(instr_valid), 16'h0000);
      chk("t1.next_addr", imem_addr, 16'(k + 1));
    end
    chk("t1.pc_end", pc, 16'h0003);

    // Test 2: CPU stalls 3 cycles on first instruction
    instr_ready = 1'b0;
    do_reset();
    tick();
    chk("t2.addr0", imem_addr, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t2.hold_instr", instr, 16'h1234);
      chk("t2.hold_ipc", instr_pc, 16'h0000);
      chk("t2.hold_req", 16'(imem_req), 16'h0000);
      chk("t2.hold_pc", pc, 16'h0001);
    end
    instr_ready = 1'b1;
    tick();
    chk("t2.next_req", 16'(imem_req), 16'h0001);
    chk("t2.next_addr", imem_addr, 16'h0001);

    // Test 3: jump while holding with ready low
    instr_ready = 1'b0;
    tick();
    chk("t3.held", instr, 16'h5678);
    jump = 1'b1;
    jump_addr = 16'h0100;
    tick();
    jump = 1'b0;
    chk("t3.valid_drop", 16'(instr_valid), 16'h0000);
    chk("t3.jaddr", imem_addr, 16'h0100);
    tick();
    chk("t3.ipc", instr_pc, 16'h0100);
    chk("t3.instr", instr, 16'hC0DE);
    instr_ready = 1'b1;

    // Test 4: jump to FFFF, pc wraps
    jump = 1'b1;
    jump_addr = 16'hFFFF;
    tick();
    jump = 1'b0;
    chk("t4.addr", imem_addr, 16'hFFFF);
    tick();
    chk("t4.ipc", instr_pc, 16'hFFFF);
    chk("t4.instr", instr, 16'hBEEF);
    chk("t4.pc_wrap", pc, 16'h0000);
    tick();
    chk("t4.next_addr", imem_addr, 16'h0000);

    // Test 5: ROM withholds ack -> sticky timeout, retry
    ack_en = 1'b0;
    do_reset();
    tick();
    chk("t5.req", 16'(imem_req), 16'h0001);
    for (int k = 0; k < LIM - 1; k++) begin
      tick();
      chk("t5.no_tout", 16'(fetch_timeout), 16'h0000);
    end
    tick();
    chk("t5.tout", 16'(fetch_timeout), 16'h0001);
    chk("t5.retry_req", 16'(imem_req), 16'h0001);
    chk("t5.retry_addr", imem_addr, 16'h0000);
    tick();
    tick();
    ack_en = 1'b1;
    tick();
    chk("t5.late_instr", instr, 16'h1234);
    chk("t5.late_valid", 16'(instr_valid), 16'h0001);
    chk("t5.sticky", 16'(fetch_timeout), 16'h0001);

    // Test 6: async reset mid-REQ
    ack_en = 1'b0;
    tick();
    chk("t6.in_req", 16'(imem_req), 16'h0001);
    #2 reset = 1'b1;
    #1;
    chk("t6.req", 16'(imem_req), 16'h0000);
    chk("t6.valid", 16'(instr_valid), 16'h0000);
    chk("t6.instr", instr, 16'h0000);
    chk("t6.ipc", instr_pc, 16'h0000);
    chk("t6.pc", pc, 16'h0000);
    chk("t6.tout", 16'(fetch_timeout), 16'h0000);
    tick();
    reset = 1'b0;
    ack_en = 1'b1;
    tick();
    chk("t6.refetch", imem_addr, 16'h0000);
    tick();
    chk("t6.instr2", instr, 16'h1234);

    $display("Simulation finished: %0d checks, %0d errors", checks,
             errors);
    $finish;
  end

endmodule
